// File: rtl/fifo_tx_drain.sv
// -----------------------------------------------------------------------------
// fifo_tx_drain
//
// Output-side drain stage for the packet FIFO. Words are popped from the shared
// SRAM FIFO whenever it is non-empty and the output buffer has room for both the
// words already held and the word still in the SRAM read pipeline. Each popped
// word lands in a small circular output buffer one cycle after its pop (SRAM read
// latency). It is then offered on a valid/ready port toward the MAC/output queue.
// A framing tracker watches the ctrl byte of every transferred word. It delimits
// packets and reports per-packet status.
//
// Optional feature macro: TX_DRAIN_STATS_EN
//    defined     : pkt_count / word_count are live 32-bit wrapping counters
//    not defined : both counters are tied to zero and no registers are built
//
// Parameters
//    DWIDTH      FIFO word width; ctrl = [DWIDTH-1:DWIDTH-8], data = [DWIDTH-9:0]
//    OBUF_DEPTH  output buffer entries (power of two, >= 2)
//    HDR_CTRL    ctrl value marking the first (module-header) word of a packet
//
// Ports
//    clk         clock
//    reset_n     synchronous active-low reset (also resets the FIFO itself)
//    fifo_empty  FIFO empty or TX stopped; no pop while high
//    fifo_output SRAM read data, valid the cycle after the popping reb
//    reb         FIFO pop strobe
//    out_data    data field of the buffer head word
//    out_ctrl    ctrl field of the buffer head word
//    out_wr      head word is valid and transferred this cycle
//    out_rdy     downstream can accept a word this cycle
//    in_pkt      high from header-word transfer through last-word transfer
//    pkt_done    one-cycle pulse after the last word of a packet transferred
//    frame_err   sticky framing-violation flag
//    pkt_count   packets completed
//    word_count  words transferred
// -----------------------------------------------------------------------------
module fifo_tx_drain #(
   parameter int         DWIDTH     = 72,
   parameter int         OBUF_DEPTH = 4,
   parameter logic [7:0] HDR_CTRL   = 8'hFF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fifo_empty,
   input  logic [DWIDTH-1:0] fifo_output,
   output logic              reb,
   output logic [DWIDTH-9:0] out_data,
   output logic [7:0]        out_ctrl,
   output logic              out_wr,
   input  logic              out_rdy,
   output logic              in_pkt,
   output logic              pkt_done,
   output logic              frame_err,
   output logic [31:0]       pkt_count,
   output logic [31:0]       word_count
);

   localparam int PTR_W = $clog2(OBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   // One extra bit so buf_cnt + inflight can never wrap in the credit compare.
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } frame_state_t;

   // ---------------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------------
   logic [DWIDTH-1:0] obuf_r [OBUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  buf_cnt_r;
   logic              inflight_r;

   frame_state_t      state_r;
   logic              in_pkt_r;
   logic              pkt_done_r;
   logic              frame_err_r;

   logic [OCC_W-1:0]  occupancy_s;
   logic              reb_s;
   logic              out_wr_s;
   logic [DWIDTH-1:0] head_word_s;
   logic [7:0]        head_ctrl_s;
   logic              is_hdr_s;
   logic              is_body_s;
   logic              last_word_s;

   // Credit check: buffered words plus the word in the SRAM read pipeline must
   // leave room for one more pop. The reset gate keeps the FIFO untouched while
   // both sides are being reset together.
   always_comb begin
      occupancy_s = OCC_W'(buf_cnt_r) + OCC_W'(inflight_r);
      if (reset_n && !fifo_empty && (occupancy_s < OCC_W'(OBUF_DEPTH))) begin
         reb_s = 1'b1;
      end else begin
         reb_s = 1'b0;
      end
   end

   // Head-of-buffer view and transfer qualification. The head is never bypassed
   // from fifo_output, so a freshly captured word is first visible next cycle.
   always_comb begin
      head_word_s = obuf_r[rd_ptr_r];
      head_ctrl_s = head_word_s[DWIDTH-1:DWIDTH-8];
      if (reset_n && (buf_cnt_r != CNT_W'(0)) && out_rdy) begin
         out_wr_s = 1'b1;
      end else begin
         out_wr_s = 1'b0;
      end
   end

   // Classify the ctrl byte of the word being transferred this cycle.
   always_comb begin
      is_hdr_s    = (head_ctrl_s == HDR_CTRL);
      is_body_s   = (head_ctrl_s == 8'h00);
      last_word_s = 1'b0;
      case (state_r)
         ST_BODY: begin
            if (out_wr_s && !is_hdr_s && !is_body_s) begin
               last_word_s = 1'b1;
            end else begin
               last_word_s = 1'b0;
            end
         end
         ST_IDLE: last_word_s = 1'b0;
         default: last_word_s = 1'b0;
      endcase
   end

   // Output buffer: capture the in-flight SRAM word at the tail, pop the head on
   // transfer; the occupancy count tracks the difference.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            obuf_r[i] <= '0;
         end
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         buf_cnt_r  <= '0;
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= reb_s;
         if (inflight_r) begin
            obuf_r[wr_ptr_r] <= fifo_output;
            wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
         end
         if (out_wr_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({inflight_r, out_wr_s})
            2'b10:   buf_cnt_r <= buf_cnt_r + CNT_W'(1);
            2'b01:   buf_cnt_r <= buf_cnt_r - CNT_W'(1);
            default: buf_cnt_r <= buf_cnt_r;
         endcase
      end
   end

   // Framing tracker, advanced only by transferred words. A header seen inside
   // a packet is flagged but restarts the packet, so the tracker stays in BODY.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         in_pkt_r    <= 1'b0;
         pkt_done_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         pkt_done_r <= 1'b0;
         if (out_wr_s) begin
            case (state_r)
               ST_IDLE: begin
                  if (is_hdr_s) begin
                     state_r  <= ST_BODY;
                     in_pkt_r <= 1'b1;
                  end else begin
                     frame_err_r <= 1'b1;
                  end
               end
               ST_BODY: begin
                  if (is_hdr_s) begin
                     frame_err_r <= 1'b1;
                  end else if (last_word_s) begin
                     pkt_done_r <= 1'b1;
                     in_pkt_r   <= 1'b0;
                     state_r    <= ST_IDLE;
                  end
               end
               default: begin
                  state_r  <= ST_IDLE;
                  in_pkt_r <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef TX_DRAIN_STATS_EN
   logic [31:0] pkt_cnt_r;
   logic [31:0] word_cnt_r;

   // Statistics counters; both wrap modulo 2^32. The packet counter steps on the
   // same edge that raises pkt_done, so the two become visible together.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_cnt_r  <= 32'd0;
         word_cnt_r <= 32'd0;
      end else begin
         if (out_wr_s) begin
            word_cnt_r <= word_cnt_r + 32'd1;
         end
         if (last_word_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
         end
      end
   end

   assign pkt_count  = pkt_cnt_r;
   assign word_count = word_cnt_r;
`else
   assign pkt_count  = 32'd0;
   assign word_count = 32'd0;
`endif

   assign reb       = reb_s;
   assign out_wr    = out_wr_s;
   assign out_data  = head_word_s[DWIDTH-9:0];
   assign out_ctrl  = head_ctrl_s;
   assign in_pkt    = in_pkt_r;
   assign pkt_done  = pkt_done_r;
   assign frame_err = frame_err_r;

endmodule
